// File: rtl/load_store_unit.sv
// Memory-access stage: drives a single-outstanding req/gnt/rvalid data bus,
// splits misaligned accesses into two aligned words and extends load results.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_l3,
  input  logic [31:0] addr_l3,
  input  logic [31:0] wdata_l3,
  input  logic        ins_lb_l3,
  input  logic        ins_lh_l3,
  input  logic        ins_lw_l3,
  input  logic        ins_lbu_l3,
  input  logic        ins_lhu_l3,
  input  logic        ins_sb_l3,
  input  logic        ins_sh_l3,
  input  logic        ins_sw_l3,
  output logic        stall_l3,
  output logic        done_l3,
  output logic [31:0] rdata_l3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata, r_r0, r_rdata;
  logic [1:0]  r_size;
  logic        r_sext, r_we;

  logic        w_is_mem, w_start, w_sext_in, w_we_in, w_split;
  logic [1:0]  w_size_in, w_off;
  logic [3:0]  w_mask;
  logic [7:0]  w_be8;
  logic [63:0] w_wdata64;
  logic [31:0] w_word0, w_word1, w_r0, w_r1, w_shifted, w_ext;

  assign w_is_mem  = ins_lb_l3 | ins_lh_l3 | ins_lw_l3 | ins_lbu_l3 | ins_lhu_l3 |
                     ins_sb_l3 | ins_sh_l3 | ins_sw_l3;
  assign w_start   = valid_l3 & w_is_mem & (r_state == S_IDLE);
  assign w_sext_in = ins_lb_l3 | ins_lh_l3;
  assign w_we_in   = ins_sb_l3 | ins_sh_l3 | ins_sw_l3;
  // size code: 0 = byte, 1 = half, 2 = word
  assign w_size_in = (ins_lb_l3 | ins_lbu_l3 | ins_sb_l3) ? 2'd0 :
                     (ins_lh_l3 | ins_lhu_l3 | ins_sh_l3) ? 2'd1 : 2'd2;

  assign w_off     = r_addr[1:0];
  assign w_mask    = (r_size == 2'd0) ? 4'b0001 : (r_size == 2'd1) ? 4'b0011 : 4'b1111;
  assign w_be8     = {4'b0000, w_mask} << w_off;
  assign w_split   = |w_be8[7:4];
  assign w_wdata64 = {32'd0, r_wdata} << {w_off, 3'b000};
  assign w_word0   = {r_addr[31:2], 2'b00};
  assign w_word1   = w_word0 + 32'd4;

  // Combine the word arriving this cycle with the one captured earlier
  assign w_r0      = (r_state == S_WAIT0) ? mem_rdata : r_r0;
  assign w_r1      = (r_state == S_WAIT1) ? mem_rdata : 32'd0;
  assign w_shifted = 32'({w_r1, w_r0} >> {w_off, 3'b000});

  always_comb begin
    w_ext = w_shifted;
    case (r_size)
      2'd0:    w_ext = {{24{r_sext & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_ext = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)    w_state_next = S_REQ0;
      S_REQ0:  if (mem_gnt)    w_state_next = S_WAIT0;
      S_WAIT0: if (mem_rvalid) w_state_next = w_split ? S_REQ1 : S_DONE;
      S_REQ1:  if (mem_gnt)    w_state_next = S_WAIT1;
      S_WAIT1: if (mem_rvalid) w_state_next = S_DONE;
      S_DONE:                  w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    if (r_state == S_REQ0) begin
      mem_req   = 1'b1;
      mem_we    = r_we;
      mem_addr  = w_word0;
      mem_be    = w_be8[3:0];
      mem_wdata = r_we ? w_wdata64[31:0] : 32'd0;
    end else if (r_state == S_REQ1) begin
      mem_req   = 1'b1;
      mem_we    = r_we;
      mem_addr  = w_word1;
      mem_be    = w_be8[7:4];
      mem_wdata = r_we ? w_wdata64[63:32] : 32'd0;
    end
  end

  assign stall_l3 = ~rst & (w_start | (r_state == S_REQ0) | (r_state == S_WAIT0) |
                            (r_state == S_REQ1) | (r_state == S_WAIT1));
  assign done_l3  = (r_state == S_DONE);
  assign rdata_l3 = r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_r0    <= 32'd0;
      r_rdata <= 32'd0;
      r_size  <= 2'd0;
      r_sext  <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_addr  <= addr_l3;
        r_wdata <= wdata_l3;
        r_size  <= w_size_in;
        r_sext  <= w_sext_in;
        r_we    <= w_we_in;
      end
      if ((r_state == S_WAIT0) && mem_rvalid)
        r_r0 <= mem_rdata;
      // Stores leave the previous load result untouched
      if ((w_state_next == S_DONE) && (r_state != S_DONE) && !r_we)
        r_rdata <= w_ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver plays pipeline and memory,
// a negedge monitor checks bus requests and completed accesses against queues.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_l3;
  logic [31:0] addr_l3, wdata_l3;
  logic        ins_lb_l3, ins_lh_l3, ins_lw_l3, ins_lbu_l3, ins_lhu_l3;
  logic        ins_sb_l3, ins_sh_l3, ins_sw_l3;
  logic        stall_l3, done_l3;
  logic [31:0] rdata_l3;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  int          tests = 0;
  int          fails = 0;

  localparam int OP_LB = 0, OP_LH = 1, OP_LW = 2, OP_LBU = 3, OP_LHU = 4,
                 OP_SB = 5, OP_SH = 6, OP_SW = 7;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .valid_l3(valid_l3), .addr_l3(addr_l3), .wdata_l3(wdata_l3),
    .ins_lb_l3(ins_lb_l3), .ins_lh_l3(ins_lh_l3), .ins_lw_l3(ins_lw_l3),
    .ins_lbu_l3(ins_lbu_l3), .ins_lhu_l3(ins_lhu_l3), .ins_sb_l3(ins_sb_l3),
    .ins_sh_l3(ins_sh_l3), .ins_sw_l3(ins_sw_l3), .stall_l3(stall_l3), .done_l3(done_l3),
    .rdata_l3(rdata_l3), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input int op);
    ins_lb_l3  = (op == OP_LB);
    ins_lh_l3  = (op == OP_LH);
    ins_lw_l3  = (op == OP_LW);
    ins_lbu_l3 = (op == OP_LBU);
    ins_lhu_l3 = (op == OP_LHU);
    ins_sb_l3  = (op == OP_SB);
    ins_sh_l3  = (op == OP_SH);
    ins_sw_l3  = (op == OP_SW);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [3:0] be,
                          input logic we, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly, input logic [31:0] rd0,
                        input logic [31:0] rd1, input int exp_stall, input string name);
    int  stalls = 0, gc = 0, rc = 0, word = 0;
    bit  pend = 0, got_done = 0;
    valid_l3 = 1'b1; addr_l3 = addr; wdata_l3 = wd; set_op(op);
    for (int c = 0; c < 200 && !got_done; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
      if (pend && !mem_req && !done_l3) begin
        if (rc == rdly) begin
          mem_rvalid = 1'b1; mem_rdata = (word == 0) ? rd0 : rd1;
          word++; rc = 0; pend = 0;
        end else rc++;
      end
      if (mem_req) begin
        if (gc == gdly) begin mem_gnt = 1'b1; gc = 0; pend = 1; end
        else gc++;
      end
      #1;
      if (stall_l3) stalls++;
      if (done_l3) got_done = 1;
      else begin @(posedge clk); #1; end
    end
    tests++;
    if (!got_done) begin
      fails++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    check({name, "_stall"}, stalls, exp_stall);
    valid_l3 = 1'b0; set_op(-1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    @(posedge clk); #1;
  endtask

  // Monitor: compares bus requests every REQ cycle (stability), pops on grant
  always @(negedge clk) begin
    if (mem_req) begin
      tests++;
      if (bus_q.size() == 0) begin
        fails++;
        $display("FAIL bus_unexpected: got addr %h be %b expected no request", mem_addr, mem_be);
      end else begin
        if (mem_addr !== bus_q[0].addr || mem_be !== bus_q[0].be ||
            mem_we !== bus_q[0].we || mem_wdata !== bus_q[0].wdata) begin
          fails++;
          $display("FAIL bus_req: got addr %h be %b we %b wdata %h expected addr %h be %b we %b wdata %h",
                   mem_addr, mem_be, mem_we, mem_wdata,
                   bus_q[0].addr, bus_q[0].be, bus_q[0].we, bus_q[0].wdata);
        end
        if (mem_gnt) begin
          $display("[TB] bus txn addr=%h be=%b we=%b wdata=%h", mem_addr, mem_be, mem_we, mem_wdata);
          void'(bus_q.pop_front());
        end
      end
    end else begin
      tests++;
      if (mem_addr !== 32'd0 || mem_be !== 4'd0 || mem_we !== 1'b0 || mem_wdata !== 32'd0) begin
        fails++;
        $display("FAIL bus_idle_zero: got addr %h be %b we %b wdata %h expected all 0",
                 mem_addr, mem_be, mem_we, mem_wdata);
      end
    end
    if (done_l3) begin
      tests++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: got done expected none");
      end else begin
        if (rdata_l3 !== rd_q[0]) begin
          fails++;
          $display("FAIL rdata: got %h expected %h", rdata_l3, rd_q[0]);
        end else
          $display("[TB] done rdata_l3=%h", rdata_l3);
        void'(rd_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; valid_l3 = 1'b1; addr_l3 = 32'h100; wdata_l3 = 32'd0; set_op(OP_LW);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall_l3}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_done", {31'd0, done_l3}, 32'd0);
    check("rst_rdata", rdata_l3, 32'd0);
    valid_l3 = 1'b0; set_op(-1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // valid with no memory op does nothing
    valid_l3 = 1'b1;
    #1;
    check("noop_stall", {31'd0, stall_l3}, 32'd0);
    @(posedge clk); #1;
    check("noop_req", {31'd0, mem_req}, 32'd0);
    check("noop_done", {31'd0, done_l3}, 32'd0);
    valid_l3 = 1'b0;
    @(posedge clk); #1;

    push_bus(32'h100, 4'b1111, 1'b0, 32'd0); rd_q.push_back(32'hDEADBEEF);
    run_op(OP_LW, 32'h100, 32'd0, 0, 0, 32'hDEADBEEF, 32'd0, 3, "lw");

    push_bus(32'h200, 4'b1000, 1'b0, 32'd0); rd_q.push_back(32'hFFFFFF80);
    run_op(OP_LB, 32'h203, 32'd0, 0, 0, 32'h80123456, 32'd0, 3, "lb");

    push_bus(32'h200, 4'b1000, 1'b0, 32'd0); rd_q.push_back(32'h00000080);
    run_op(OP_LBU, 32'h203, 32'd0, 0, 0, 32'h80123456, 32'd0, 3, "lbu");

    push_bus(32'h100, 4'b1100, 1'b1, 32'h33440000);
    push_bus(32'h104, 4'b0011, 1'b1, 32'h00001122);
    rd_q.push_back(32'h00000080);
    run_op(OP_SW, 32'h102, 32'h11223344, 0, 0, 32'd0, 32'd0, 5, "sw_split");

    push_bus(32'hFFFFFFFC, 4'b1000, 1'b0, 32'd0);
    push_bus(32'h00000000, 4'b0001, 1'b0, 32'd0);
    rd_q.push_back(32'hFFFFCDAB);
    run_op(OP_LH, 32'hFFFFFFFF, 32'd0, 0, 0, 32'hAB000000, 32'h000000CD, 5, "lh_wrap");

    push_bus(32'h004, 4'b1100, 1'b1, 32'hBEEF0000); rd_q.push_back(32'hFFFFCDAB);
    run_op(OP_SH, 32'h006, 32'hCAFEBEEF, 3, 1, 32'd0, 32'd0, 7, "sh_wait");

    push_bus(32'h008, 4'b1100, 1'b0, 32'd0); rd_q.push_back(32'h00008001);
    run_op(OP_LHU, 32'h00A, 32'd0, 1, 0, 32'h80010000, 32'd0, 4, "lhu");

    push_bus(32'h008, 4'b1100, 1'b0, 32'd0); rd_q.push_back(32'hFFFF8001);
    run_op(OP_LH, 32'h00A, 32'd0, 0, 0, 32'h80010000, 32'd0, 3, "lh");

    push_bus(32'h000, 4'b0010, 1'b1, 32'h3456A500); rd_q.push_back(32'hFFFF8001);
    run_op(OP_SB, 32'h001, 32'h123456A5, 0, 0, 32'd0, 32'd0, 3, "sb");

    // reset while waiting for the response, then a late rvalid
    push_bus(32'h300, 4'b1111, 1'b0, 32'd0);
    valid_l3 = 1'b1; addr_l3 = 32'h300; wdata_l3 = 32'd0; set_op(OP_LW);
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1; valid_l3 = 1'b0; set_op(-1);
    #1;
    check("midrst_req", {31'd0, mem_req}, 32'd0);
    check("midrst_stall", {31'd0, stall_l3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) begin
      check("midrst_done", {31'd0, done_l3}, 32'd0);
      check("midrst_req_after", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
    end
    check("midrst_rdata", rdata_l3, 32'd0);

    push_bus(32'h104, 4'b1111, 1'b0, 32'd0); rd_q.push_back(32'h55AA55AA);
    run_op(OP_LW, 32'h104, 32'd0, 0, 0, 32'h55AA55AA, 32'd0, 3, "lw_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("bus_q_empty", bus_q.size(), 32'd0);
    check("rd_q_empty", rd_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
